// File: rtl/nibble_serial_addsub_pkg.sv
// Shared constants for the nibble-serial add/subtract unit.
// FSM state encoding and the nibble width.
package nibble_serial_addsub_pkg;

  localparam int NIBBLE = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/nibble_serial_addsub_cla.sv
// 4-bit carry-lookahead unit: p, g, cin -> carry[3:0], cout.
// carry[i] is the carry into bit i (carry[0] = cin).
module nibble_serial_addsub_cla (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       cin,
  output logic [3:0] carry,
  output logic       cout
);

  always_comb begin
    carry[0] = cin;
    carry[1] = g[0]
             | (p[0] & cin);
    carry[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & cin);
    carry[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
    cout     = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
  end

endmodule

// File: rtl/nibble_serial_addsub.sv
// Iterative WIDTH-bit add/sub, one nibble per clock, LSB first.
// Ports: clk, rst_n, start, sub, a, b -> busy, done, result, cout, overflow, zero.
module nibble_serial_addsub
  import nibble_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / NIBBLE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [IW-1:0]    idx;

  logic [IW+1:0]    sh;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [3:0]       p;
  logic [3:0]       g;
  logic [3:0]       carry;
  logic             c_out;
  logic [3:0]       sum;
  logic [WIDTH-1:0] next_result;
  logic             last;

  // Bit offset of the current nibble is idx * 4.
  always_comb begin
    sh          = {idx, 2'b00};
    a_sh        = a_r >> sh;
    b_sh        = b_r >> sh;
    p           = a_sh[3:0] ^ b_sh[3:0];
    g           = a_sh[3:0] & b_sh[3:0];
    sum         = p ^ carry;
    next_result = (result & ~(WIDTH'(4'hF) << sh))
                | (WIDTH'(sum) << sh);
    last        = (idx == IW'(N - 1));
  end

  nibble_serial_addsub_cla lookahead_adder (
    .p     (p),
    .g     (g),
    .cin   (carry_r),
    .carry (carry),
    .cout  (c_out)
  );

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      a_r      <= '0;
      b_r      <= '0;
      carry_r  <= 1'b0;
      idx      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            // Subtract as a + ~b + 1: the +1 enters as carry-in.
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub;
            idx     <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          result  <= next_result;
          carry_r <= c_out;
          idx     <= idx + 1'b1;
          if (last) begin
            cout     <= c_out;
            overflow <= carry[3] ^ c_out;
            zero     <= (next_result == '0);
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Self-checking bench for nibble_serial_addsub (WIDTH=16).
// Random and directed ops vs an arithmetic reference model.
module tb_nibble_serial_addsub;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic         zero;

  int n_tests;
  int n_fail;

  nibble_serial_addsub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".result"}, 32'(result), 32'd0);
    chk({tag, ".cout"}, 32'(cout), 32'd0);
    chk({tag, ".ovf"}, 32'(overflow), 32'd0);
    chk({tag, ".zero"}, 32'(zero), 32'd1);
  endtask

  // Reference: plain two's-complement arithmetic.
  task automatic run_op(input logic s,
                        input logic [W-1:0] x,
                        input logic [W-1:0] y,
                        input bit poke);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         co;
    logic         ov;
    int           cnt;
    bit           got;

    if (s) full = {1'b0, x} + {1'b0, ~y} + 17'd1;
    else   full = {1'b0, x} + {1'b0, y};
    r  = full[W-1:0];
    co = full[W];
    if (s) ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    else   ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);

    @(negedge clk);
    start = 1'b1;
    sub   = s;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    sub   = 1'($urandom);

    cnt = 0;
    got = 0;
    while (!got && cnt < 20) begin
      if (poke && cnt == 1) begin
        start = 1'b1;
        a     = W'($urandom);
        b     = W'($urandom);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cnt++;
      if (done) got = 1;
      else if (cnt < N) chk("busy_run", 32'(busy), 32'd1);
    end

    chk("latency", 32'(cnt), 32'(N));
    chk("result", 32'(result), 32'(r));
    chk("cout", 32'(cout), 32'(co));
    chk("overflow", 32'(overflow), 32'(ov));
    chk("zero", 32'(zero), 32'(r == '0));
    chk("busy_done", 32'(busy), 32'd0);

    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk("done_pulse", 32'(done), 32'd0);
      chk("result_hold", 32'(result), 32'(r));
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    sub     = 1'b0;
    a       = '0;
    b       = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b0, 16'h1234, 16'h4321, 1'b0);
    run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    run_op(1'b1, 16'h0005, 16'h0007, 1'b0);
    run_op(1'b1, 16'h0007, 16'h0005, 1'b0);
    run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    run_op(1'b1, 16'h8000, 16'h0001, 1'b0);
    run_op(1'b1, 16'h1234, 16'h1234, 1'b0);
    run_op(1'b0, 16'h0A0A, 16'h5050, 1'b1);

    // Abort mid-RUN once two nibbles have completed.
    @(negedge clk);
    start = 1'b1;
    sub   = 1'b0;
    a     = 16'h1111;
    b     = 16'h2222;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("abort_nodone", 32'(done), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 16'h0001, 16'h0001, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(1'($urandom), W'($urandom), W'($urandom),
             ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
